// File: rtl/tm_pkg.sv
// Shared types and constants for the TuringMachine program driver.
package tm_pkg;

  localparam int DATA_W = 6;
  localparam int DISP_W = 11;
  localparam int TMR_W  = 8;

  localparam logic [1:0] PH_RULES = 2'd0;
  localparam logic [1:0] PH_TAPE  = 2'd1;
  localparam logic [1:0] PH_RUN   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DPULSE,
    S_DGAP,
    S_SETTLE,
    S_RUN_IDLE,
    S_RUN_PULSE,
    S_RUN_WAIT,
    S_HALT
  } tm_drv_state_t;

endpackage

// File: rtl/tm_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tm_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/tm_program_driver.sv
// Replays loaded entries as TuringMachine Next/Done pulses, then single-steps it.
// Optional macro TM_DRIVER_AUTORUN_EN: step continuously until halt or step saturation.
module tm_program_driver
  import tm_pkg::*;
#(
  parameter int SETUP_CYC     = 3,
  parameter int PULSE_CYC     = 2,
  parameter int GAP_CYC       = 2,
  parameter int SETTLE_CYC    = 20,
  parameter int STEP_WAIT_CYC = 5,
  parameter int MAX_STEPS     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_step,
  input  logic [DISP_W-1:0] display_in,
  input  logic              compute_done_in,
  output logic [DATA_W-1:0] input_data,
  output logic              Next,
  output logic              Done,
  output logic              snap_valid,
  output logic [DISP_W-1:0] snap_data,
  output logic [7:0]        step_count,
  output logic [1:0]        phase,
  output logic              finished
);

  tm_drv_state_t    state, state_next;
  logic [1:0]       phase_next;
  logic             last;
  logic             accept;
  logic             sample;
  logic             halt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic [7:0]       step_inc;

  tm_pulse_timer #(.W(TMR_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  assign step_inc = (step_count == 8'(MAX_STEPS)) ? step_count : step_count + 8'd1;

  always_comb begin
    state_next = state;
    phase_next = phase;
    accept     = 1'b0;
    sample     = 1'b0;
    halt       = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      S_IDLE: begin
        if (phase != PH_RUN && load_valid && load_ready) begin
          accept     = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP:  if (tmr_done) state_next = S_PULSE;
      S_PULSE:  if (tmr_done) state_next = S_GAP;
      S_GAP:    if (tmr_done) state_next = last ? S_DPULSE : S_IDLE;
      S_DPULSE: if (tmr_done) state_next = S_DGAP;
      S_DGAP: begin
        if (tmr_done) begin
          phase_next = phase + 2'd1;
          state_next = (phase == PH_RULES) ? S_IDLE : S_SETTLE;
        end
      end
      S_SETTLE: if (tmr_done) state_next = S_RUN_IDLE;
      S_RUN_IDLE: begin
`ifdef TM_DRIVER_AUTORUN_EN
        state_next = S_RUN_PULSE;
`else
        if (run_step) state_next = S_RUN_PULSE;
`endif
      end
      S_RUN_PULSE: if (tmr_done) state_next = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (tmr_done) begin
          sample = 1'b1;
`ifdef TM_DRIVER_AUTORUN_EN
          halt = compute_done_in || (step_inc == 8'(MAX_STEPS));
`else
          halt = compute_done_in;
`endif
          state_next = halt ? S_HALT : S_RUN_IDLE;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase

    // Every timed state is entered from a different state, so a state change reloads the timer.
    tmr_load = (state_next != state);
    case (state_next)
      S_SETUP:     tmr_val = TMR_W'(SETUP_CYC - 1);
      S_PULSE,
      S_DPULSE,
      S_RUN_PULSE: tmr_val = TMR_W'(PULSE_CYC - 1);
      S_GAP,
      S_DGAP:      tmr_val = TMR_W'(GAP_CYC - 1);
      S_SETTLE:    tmr_val = TMR_W'(SETTLE_CYC - 1);
      S_RUN_WAIT:  tmr_val = TMR_W'(STEP_WAIT_CYC - 1);
      default:     tmr_val = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      phase      <= PH_RULES;
      last       <= 1'b0;
      input_data <= '0;
      Next       <= 1'b0;
      Done       <= 1'b0;
      load_ready <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= '0;
      step_count <= '0;
      finished   <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      Next       <= (state_next == S_PULSE) || (state_next == S_RUN_PULSE);
      Done       <= (state_next == S_DPULSE);
      load_ready <= (state_next == S_IDLE) && (phase_next != PH_RUN);
      snap_valid <= sample;
      if (accept) begin
        input_data <= load_data;
        last       <= load_last;
      end
      if (sample) begin
        snap_data  <= display_in;
        step_count <= step_inc;
        if (halt) finished <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tm_program_driver.sv
// Randomized bench for tm_program_driver against a timeline-based reference model.
module tb_tm_program_driver;
  import tm_pkg::*;

  localparam int S    = 3;
  localparam int P    = 2;
  localparam int G    = 2;
  localparam int T    = 20;
  localparam int W    = 5;
  localparam int MAXS = 255;
  localparam int INF  = 1 << 30;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              run_step;
  logic [DISP_W-1:0] display_in;
  logic              compute_done_in;
  logic [DATA_W-1:0] input_data;
  logic              Next;
  logic              Done;
  logic              snap_valid;
  logic [DISP_W-1:0] snap_data;
  logic [7:0]        step_count;
  logic [1:0]        phase;
  logic              finished;

  always #5 clock = ~clock;

  tm_program_driver dut (
    .clock           (clock),
    .reset           (reset),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .load_last       (load_last),
    .load_ready      (load_ready),
    .run_step        (run_step),
    .display_in      (display_in),
    .compute_done_in (compute_done_in),
    .input_data      (input_data),
    .Next            (Next),
    .Done            (Done),
    .snap_valid      (snap_valid),
    .snap_data       (snap_data),
    .step_count      (step_count),
    .phase           (phase),
    .finished        (finished)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: absolute edge numbers of upcoming events; values describe the state after edge cyc.
  int   idle_from, nxt_a, nxt_b, don_a, don_b, ph_at, ph_val, snap_edge;
  int   m_phase, m_input, m_snap, m_step;
  logic m_fin, m_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int   e, g, ph_before;
    logic free_before;
    e = cyc;
    if (!reset) begin
      m_phase = 0; m_input = 0; m_snap = 0; m_step = 0; m_fin = 1'b0; m_rst = 1'b1;
      idle_from = e + 1; nxt_a = -10; nxt_b = -20; don_a = -10; don_b = -20;
      ph_at = -1; ph_val = 0; snap_edge = -1;
      return;
    end
    m_rst       = 1'b0;
    free_before = (idle_from <= e - 1);
    ph_before   = m_phase;
    if (e == ph_at) m_phase = ph_val;
    if (e == snap_edge) begin
      m_snap = int'(display_in);
      if (m_step < MAXS) m_step++;
      if (compute_done_in) begin
        m_fin = 1'b1;
        idle_from = INF;
      end else begin
        idle_from = e;
      end
    end
    if (free_before && ph_before < 2 && load_valid) begin
      m_input = int'(load_data);
      nxt_a = e + S;
      nxt_b = e + S + P - 1;
      g = e + S + P + G;
      if (!load_last) begin
        idle_from = g;
      end else begin
        don_a = g;
        don_b = g + P - 1;
        ph_at = g + P + G;
        ph_val = ph_before + 1;
        idle_from = (ph_val == 1) ? ph_at : ph_at + T;
      end
    end else if (free_before && ph_before == 2 && !m_fin && run_step) begin
      nxt_a = e;
      nxt_b = e + P - 1;
      snap_edge = e + P + W;
      idle_from = snap_edge;
    end
  endtask

  task automatic compare();
    int e;
    e = cyc;
    chk("next",       32'(Next),       32'(e >= nxt_a && e <= nxt_b));
    chk("done",       32'(Done),       32'(e >= don_a && e <= don_b));
    chk("load_ready", 32'(load_ready), 32'(!m_rst && m_phase < 2 && idle_from <= e));
    chk("snap_valid", 32'(snap_valid), 32'(!m_rst && e == snap_edge));
    chk("input_data", 32'(input_data), 32'(m_input));
    chk("snap_data",  32'(snap_data),  32'(m_snap));
    chk("step_count", 32'(step_count), 32'(m_step));
    chk("phase",      32'(phase),      32'(m_phase));
    chk("finished",   32'(finished),   32'(m_fin));
  endtask

  task automatic step_cycle();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic drive_random(input bit saturate);
    load_valid      = ($urandom_range(9) < 6);
    load_data       = DATA_W'($urandom);
    load_last       = ($urandom_range(5) == 0);
    run_step        = saturate ? 1'b1 : ($urandom_range(9) < 3);
    display_in      = DISP_W'($urandom);
    compute_done_in = saturate ? 1'b0 : ($urandom_range(19) == 0);
  endtask

  task automatic run_round(input int n, input bit saturate, input bit inject);
    bit injected;
    injected = 1'b0;
    reset = 1'b0;
    drive_random(saturate);
    step_cycle();
    step_cycle();
    for (int i = 0; i < n; i++) begin
      drive_random(saturate);
      reset = 1'b1;
      // Pull reset while Next is high to cover an interrupted pulse.
      if (inject && !injected && i > 30 && cyc >= nxt_a && cyc <= nxt_b) begin
        reset = 1'b0;
        injected = 1'b1;
      end
      step_cycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    run_step = 1'b0; display_in = '0; compute_done_in = 1'b0;
    step_cycle();
    step_cycle();
    for (int r = 0; r < 6; r++) begin
      run_round(700, 1'b0, (r == 1) || (r == 3));
    end
    run_round(2800, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
